// File: rtl/interrupt_controller.sv
// Prioritised interrupt front-end: captures request lines, latches edges as pending, masks and
// arbitrates, then holds one registered request until acknowledged. Define IC_SYNC_EN for a 2-flop input synchroniser.
module interrupt_controller #(
  parameter int unsigned NUM_IRQ    = 4,
  parameter int unsigned IID_W      = 2,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0010,
  parameter int unsigned VEC_STRIDE = 4
) (
  input  logic               Clock,
  input  logic               SysReset,
  input  logic [NUM_IRQ-1:0] IrqIn,
  input  logic [NUM_IRQ-1:0] EdgeMode,
  input  logic               MaskWe,
  input  logic [NUM_IRQ-1:0] MaskWd,
  input  logic               Supervisor,
  input  logic               ExcAckEX,
  input  logic               IntDone,
  output logic               IRQ_Int,
  output logic [IID_W-1:0]   IID_Sync,
  output logic [31:0]        IntVector,
  output logic [NUM_IRQ-1:0] Mask,
  output logic [NUM_IRQ-1:0] Pending,
  output logic               InService
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} stateT;

  stateT              stateReg, stateNext;
  logic [NUM_IRQ-1:0] irqSync, irqPrev;
  logic [NUM_IRQ-1:0] maskReg, pendingReg, pendingNext, eligible;
  logic [IID_W-1:0]   iidReg, winnerId;
  logic [31:0]        vecReg;
  logic               irqReg, inServiceReg, winnerValid, reqEligible, ackTaken;

`ifdef IC_SYNC_EN
  logic [NUM_IRQ-1:0] syncMeta;

  always_ff @(posedge Clock) begin
    if (!SysReset) begin
      syncMeta <= '0;
      irqSync  <= '0;
    end else begin
      syncMeta <= IrqIn;
      irqSync  <= syncMeta;
    end
  end
`else
  always_ff @(posedge Clock) begin
    if (!SysReset) irqSync <= '0;
    else           irqSync <= IrqIn;
  end
`endif

  assign eligible = pendingReg & ~maskReg;
  assign ackTaken = (stateReg == REQ) && ExcAckEX;

  // A fresh edge in the acknowledge cycle must survive the clear.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_pend
      logic edgeSet, ackClr;
      assign edgeSet = irqSync[gi] & ~irqPrev[gi];
      assign ackClr  = ackTaken && (iidReg == IID_W'(gi));
      assign pendingNext[gi] = EdgeMode[gi] ? (edgeSet | (pendingReg[gi] & ~ackClr))
                                            : irqSync[gi];
    end
  endgenerate

  always_comb begin
    winnerId    = '0;
    winnerValid = |eligible;
    reqEligible = 1'b0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (eligible[i]) winnerId = IID_W'(i);
      if (iidReg == IID_W'(i)) reqEligible = eligible[i];
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (winnerValid && !Supervisor) stateNext = REQ;
      REQ: begin
        if (ExcAckEX)          stateNext = SERVICE;
        else if (!reqEligible) stateNext = IDLE;
      end
      SERVICE: if (IntDone) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!SysReset) begin
      stateReg     <= IDLE;
      irqPrev      <= '0;
      maskReg      <= '1;
      pendingReg   <= '0;
      iidReg       <= '0;
      vecReg       <= VEC_BASE;
      irqReg       <= 1'b0;
      inServiceReg <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      irqPrev      <= irqSync;
      pendingReg   <= pendingNext;
      irqReg       <= (stateNext == REQ);
      inServiceReg <= (stateNext == SERVICE);
      if (MaskWe) maskReg <= MaskWd;
      // ID and vector are captured once on entry to REQ and stay frozen afterwards.
      if (stateReg == IDLE && stateNext == REQ) begin
        iidReg <= winnerId;
        vecReg <= VEC_BASE + 32'(winnerId) * VEC_STRIDE;
      end
    end
  end

  assign IRQ_Int   = irqReg;
  assign IID_Sync  = iidReg;
  assign IntVector = vecReg;
  assign Mask      = maskReg;
  assign Pending   = pendingReg;
  assign InService = inServiceReg;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller (default build, single-register input capture).
module tb_interrupt_controller;

  logic        Clock = 1'b0;
  logic        SysReset, MaskWe, Supervisor, ExcAckEX, IntDone;
  logic [3:0]  IrqIn, EdgeMode, MaskWd, Mask, Pending;
  logic        IRQ_Int, InService;
  logic [1:0]  IID_Sync;
  logic [31:0] IntVector;
  int checks = 0;
  int errors = 0;

  interrupt_controller dut (
    .Clock(Clock), .SysReset(SysReset), .IrqIn(IrqIn), .EdgeMode(EdgeMode),
    .MaskWe(MaskWe), .MaskWd(MaskWd), .Supervisor(Supervisor), .ExcAckEX(ExcAckEX),
    .IntDone(IntDone), .IRQ_Int(IRQ_Int), .IID_Sync(IID_Sync), .IntVector(IntVector),
    .Mask(Mask), .Pending(Pending), .InService(InService)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    SysReset = 1'b0; IrqIn = 4'b1111; EdgeMode = 4'b0000; MaskWe = 1'b0; MaskWd = 4'b0000;
    Supervisor = 1'b0; ExcAckEX = 1'b0; IntDone = 1'b0;
    #1;
    tick(); tick();
    check("rst_irq", 32'(IRQ_Int), 32'd0);
    check("rst_mask", 32'(Mask), 32'hF);
    check("rst_pend", 32'(Pending), 32'h0);
    check("rst_vec", IntVector, 32'h10);
    check("rst_insvc", 32'(InService), 32'd0);
    check("rst_iid", 32'(IID_Sync), 32'd0);
    IrqIn = 4'b0000; SysReset = 1'b1;
    tick();

    // Single edge on channel 2
    EdgeMode = 4'b0100; MaskWe = 1'b1; MaskWd = 4'b0000;
    tick();
    MaskWe = 1'b0;
    check("mask_write", 32'(Mask), 32'h0);
    IrqIn = 4'b0100;
    tick();                                   // E
    IrqIn = 4'b0000;
    check("se_pend_E", 32'(Pending), 32'h0);
    tick();                                   // E+1
    check("se_pend_E1", 32'(Pending), 32'h4);
    check("se_irq_E1", 32'(IRQ_Int), 32'd0);
    tick();                                   // E+2
    check("se_irq_E2", 32'(IRQ_Int), 32'd1);
    check("se_iid", 32'(IID_Sync), 32'd2);
    check("se_vec", IntVector, 32'h18);
    check("se_pend_hold", 32'(Pending), 32'h4);
    ExcAckEX = 1'b1;
    tick();                                   // A
    ExcAckEX = 1'b0;
    check("se_ack_irq", 32'(IRQ_Int), 32'd0);
    check("se_ack_insvc", 32'(InService), 32'd1);
    check("se_ack_pend", 32'(Pending), 32'h0);
    IntDone = 1'b1;
    tick();
    IntDone = 1'b0;
    check("se_done_insvc", 32'(InService), 32'd0);
    check("se_done_irq", 32'(IRQ_Int), 32'd0);

    // Priority freeze: channel 3 requested, channel 1 arrives later
    EdgeMode = 4'b1110; IrqIn = 4'b1000;
    tick(); tick(); tick();
    check("pf_irq", 32'(IRQ_Int), 32'd1);
    check("pf_iid3", 32'(IID_Sync), 32'd3);
    IrqIn = 4'b1010;
    tick(); tick();
    check("pf_pend", 32'(Pending), 32'hA);
    check("pf_iid_frozen", 32'(IID_Sync), 32'd3);
    check("pf_vec_frozen", IntVector, 32'h1C);
    ExcAckEX = 1'b1;
    tick();
    ExcAckEX = 1'b0; IrqIn = 4'b0000;
    check("pf_ack_pend", 32'(Pending), 32'h2);
    check("pf_ack_insvc", 32'(InService), 32'd1);
    tick();
    check("pf_no_nest", 32'(IRQ_Int), 32'd0);
    IntDone = 1'b1;
    tick();                                   // D
    IntDone = 1'b0;
    check("pf_gap_irq", 32'(IRQ_Int), 32'd0);
    tick();                                   // D+1
    check("pf_next_irq", 32'(IRQ_Int), 32'd1);
    check("pf_next_iid", 32'(IID_Sync), 32'd1);
    check("pf_next_vec", IntVector, 32'h14);
    ExcAckEX = 1'b1; tick(); ExcAckEX = 1'b0;
    IntDone = 1'b1; tick(); IntDone = 1'b0;
    check("pf_idle_pend", 32'(Pending), 32'h0);

    // Withdraw: level channel 0 drops before acknowledge
    IrqIn = 4'b0001;
    tick(); tick(); tick();
    check("wd_irq", 32'(IRQ_Int), 32'd1);
    check("wd_iid", 32'(IID_Sync), 32'd0);
    IrqIn = 4'b0000;
    tick(); tick();
    check("wd_pend_drop", 32'(Pending), 32'h0);
    check("wd_irq_still", 32'(IRQ_Int), 32'd1);
    tick();
    check("wd_irq_gone", 32'(IRQ_Int), 32'd0);
    check("wd_insvc", 32'(InService), 32'd0);
    tick();
    check("wd_stay_idle", 32'(IRQ_Int), 32'd0);

    // Acknowledge and end-of-interrupt outside REQ are ignored
    ExcAckEX = 1'b1; IntDone = 1'b1;
    tick();
    ExcAckEX = 1'b0; IntDone = 1'b0;
    check("stray_ack_insvc", 32'(InService), 32'd0);

    // Supervisor and mask gating on edge channel 1
    Supervisor = 1'b1; IrqIn = 4'b0010;
    tick();
    IrqIn = 4'b0000;
    tick(); tick(); tick();
    check("sv_pend", 32'(Pending), 32'h2);
    check("sv_no_irq", 32'(IRQ_Int), 32'd0);
    MaskWe = 1'b1; MaskWd = 4'b0010;
    tick();
    MaskWe = 1'b0; Supervisor = 1'b0;
    tick(); tick();
    check("mk_mask", 32'(Mask), 32'h2);
    check("mk_no_irq", 32'(IRQ_Int), 32'd0);
    MaskWe = 1'b1; MaskWd = 4'b0000;
    tick();                                   // mask write lands
    MaskWe = 1'b0;
    check("mk_land_irq", 32'(IRQ_Int), 32'd0);
    tick();
    check("mk_clear_irq", 32'(IRQ_Int), 32'd1);
    check("mk_clear_iid", 32'(IID_Sync), 32'd1);
    ExcAckEX = 1'b1; tick(); ExcAckEX = 1'b0;
    IntDone = 1'b1; tick(); IntDone = 1'b0;

    // New edge on channel 2 coincides with its acknowledge
    IrqIn = 4'b0100;
    tick();                                   // E
    IrqIn = 4'b0000;
    tick(); tick();                           // E+2: request raised
    check("sim_irq", 32'(IRQ_Int), 32'd1);
    IrqIn = 4'b0100;
    tick();                                   // E+3: new edge captured
    ExcAckEX = 1'b1;
    tick();                                   // A: set and clear collide
    ExcAckEX = 1'b0; IrqIn = 4'b0000;
    check("sim_pend_kept", 32'(Pending), 32'h4);
    check("sim_insvc", 32'(InService), 32'd1);
    check("sim_irq_low", 32'(IRQ_Int), 32'd0);
    IntDone = 1'b1;
    tick();
    IntDone = 1'b0;
    tick();
    check("sim_rereq_irq", 32'(IRQ_Int), 32'd1);
    check("sim_rereq_iid", 32'(IID_Sync), 32'd2);
    ExcAckEX = 1'b1; tick(); ExcAckEX = 1'b0;
    check("sim_final_pend", 32'(Pending), 32'h0);

    // Reset from mid-SERVICE
    SysReset = 1'b0;
    tick();
    SysReset = 1'b1;
    check("rst2_insvc", 32'(InService), 32'd0);
    check("rst2_mask", 32'(Mask), 32'hF);
    check("rst2_vec", IntVector, 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
